qkv_line_aligner: RTL and testbench
===================================

Name: qkv_line_aligner

Overview:
- Sits directly downstream of the Q/K/V spike-line reshape stage and upstream of the spiking self-attention (Q·Kᵀ) systolic array.
- The three reshaped line streams (Q, K, V) arrive independently, with no backpressure and arbitrary relative skew.
- Buffers each stream in a small FIFO and releases time-aligned {Q,K,V} line triples over a valid/ready handshake.
- Tags the last triple of every frame and flags per-stream overflow.

Parameters:
- TIME_STEPS, 4, spike time steps per token.
- SYSTOLIC_UNIT_NUM, 16, tokens per half-line.
- LINE_W, 2*SYSTOLIC_UNIT_NUM*TIME_STEPS (128), bits per spike line.
- FIFO_DEPTH, 4, lines buffered per stream; power of two, ≥2.
- LINES_PER_FRAME, 64, triples per frame; ≥2.

Ports:
- s_clk  in  1  single clock, rising edge.
- s_rst  in  1  reset, asynchronous, active-high.
- i00_spikesLine_out  in  LINE_W  Q line.
- i00_spikesLine_valid  in  1  Q line strobe (1 cycle per line).
- i01_spikesLine_out  in  LINE_W  K line.
- i01_spikesLine_valid  in  1  K line strobe.
- i02_spikesLine_out  in  LINE_W  V line.
- i02_spikesLine_valid  in  1  V line strobe.
- o_q_line  out  LINE_W  aligned Q line.
- o_k_line  out  LINE_W  aligned K line.
- o_v_line  out  LINE_W  aligned V line.
- o_qkv_valid  out  1  triple valid.
- i_qkv_ready  in  1  consumer accepts the triple when o_qkv_valid && i_qkv_ready.
- o_qkv_last  out  1  triple is the last of a frame; qualified by o_qkv_valid.
- o_overflow  out  3  sticky per-stream drop flag; bit0 = Q, bit1 = K, bit2 = V.
- o_frame_done  out  1  one-cycle pulse on acceptance of the last triple.

Behaviour:
- Reset (async assert, outputs settle without a clock edge):
  - o_qkv_valid = 0, o_qkv_last = 0, o_frame_done = 0, o_overflow = 0.
  - Line outputs = 0.
  - All FIFOs empty; line counter = 0.
  - Reset asserted mid-frame discards all buffered and held lines. After release, the next triple is line 0 of a new frame.
- Push:
  - Stream k writes its line into FIFO k on the edge where its valid is high.
  - Write data is captured from the input port in the same cycle.
- Pop condition:
  - pop = all three FIFOs non-empty AND (output register empty OR accept this cycle), where accept = o_qkv_valid && i_qkv_ready.
  - A pop reads one entry from each FIFO simultaneously.
  - The popped entries are loaded into the output register, which sets o_qkv_valid.
- Output register:
  - On accept with no pop, o_qkv_valid clears.
  - While o_qkv_valid && !i_qkv_ready, the register holds; all outputs are stable.
  - Latency: when all three valids are high in cycle N with everything empty, o_qkv_valid rises in cycle N+2.
  - Sustained throughput is one triple per cycle.
- Full FIFO:
  - A push to a full FIFO in a cycle with no pop drops the incoming line and sets the matching o_overflow bit.
  - o_overflow is sticky until reset.
  - A push and pop in the same cycle on a full FIFO is legal and never counts as overflow.
- Empty FIFO: a pop is never issued while any FIFO is empty; streams that arrive early wait.
- Line counter:
  - Width $clog2(LINES_PER_FRAME).
  - Counts popped triples and wraps to 0 after LINES_PER_FRAME-1.
  - o_qkv_last is registered alongside the data: it is 1 when the loaded triple index equals LINES_PER_FRAME-1.
- o_frame_done pulses for 1 cycle in the cycle after accept of a triple with o_qkv_last = 1.
- Pointers: FIFO read/write pointers are log2(FIFO_DEPTH)+1 bits with wrap bit.
  - full = addresses equal and wrap bits differ.
  - empty = pointers equal.

Decomposition:
- Shared package / hyper-parameter include holds TIME_STEPS, SYSTOLIC_UNIT_NUM, the LINE_W derivation and the overflow bit indices (Q = 0, K = 1, V = 2).
- One sub-module, qkv_line_fifo: synchronous show-ahead register FIFO with ports din, wr_en, rd_en, dout, full, empty and a drop strobe.
  - Instantiated three times.
- Alignment, output register, counter and flags live in the top level.

Test Plan:
- Aligned stream, ready held at 1: 64 lines on all three streams in the same cycles (Q/K/V line i has payload i, 1000+i and 2000+i respectively) -> 64 triples in order with matching payloads; o_qkv_last and o_frame_done occur only on index 63; no overflow.
- Skew: Q lines at cycles 0..3, K at 5..8, V at 10..13 -> first o_qkv_valid at cycle 12; triples 0..3 correctly paired; o_overflow = 0.
- Backpressure: ready held at 0 for 20 cycles while 3 triples arrive -> o_qkv_valid high with triple 0 stable throughout; after ready rises, triples 0, 1, 2 are accepted on consecutive cycles.
- Overflow: ready = 0, 6 lines pushed on K only -> FIFO K full after 4 lines; o_overflow = 3'b010 from the 5th push onward; Q and V unaffected; flag persists until reset.
- Full with simultaneous push/pop: all FIFOs full, ready = 1, new triple arrives in the cycle a pop occurs -> accepted, no overflow bit set.
- Reset mid-frame: assert s_rst at triple 30 with 2 entries buffered -> outputs are 0 immediately; restarted traffic delivers its first triple with counter 0; o_qkv_last occurs on the 64th triple after reset.

Source files
------------

// File: rtl/qkv_line_aligner_pkg.sv
// qkv_line_aligner_pkg: shared hyper-parameters, line width and overflow bit indices
package qkv_line_aligner_pkg;
  localparam int TIME_STEPS        = 4;
  localparam int SYSTOLIC_UNIT_NUM = 16;
  localparam int LINE_W            = 2 * SYSTOLIC_UNIT_NUM * TIME_STEPS;
  localparam int FIFO_DEPTH        = 4;
  localparam int LINES_PER_FRAME   = 64;
  localparam int OVF_Q             = 0;
  localparam int OVF_K             = 1;
  localparam int OVF_V             = 2;
endpackage

// File: rtl/qkv_line_fifo.sv
// qkv_line_fifo: show-ahead register FIFO; ports din/wr_en in, rd_en in, dout/full/empty out, drop strobes a rejected push
module qkv_line_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         wr_en,
  input  logic         rd_en,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0] r_wp;
  logic [AW:0] r_rp;
  logic w_push;
  logic w_pop;
  assign full   = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
  assign empty  = r_wp == r_rp;
  assign w_pop  = rd_en && !empty;
  // a read in the same cycle frees the slot, so a push into a full FIFO is still taken
  assign w_push = wr_en && (!full || w_pop);
  assign drop   = wr_en && full && !w_pop;
  assign dout   = r_mem[r_rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + (AW+1)'(1);
      if (w_pop) r_rp <= r_rp + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) if (w_push) r_mem[r_wp[AW-1:0]] <= din;
endmodule

// File: rtl/qkv_line_aligner.sv
// qkv_line_aligner: buffers skewed Q/K/V spike lines and releases aligned triples over valid/ready
// Inputs: s_clk, s_rst (async, high), iNN_spikesLine_out/_valid for Q (00), K (01), V (02), i_qkv_ready.
// Outputs: o_q_line/o_k_line/o_v_line, o_qkv_valid, o_qkv_last, o_overflow (sticky, bit per stream), o_frame_done.
module qkv_line_aligner
  import qkv_line_aligner_pkg::*;
(
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic [LINE_W-1:0] i00_spikesLine_out,
  input  logic              i00_spikesLine_valid,
  input  logic [LINE_W-1:0] i01_spikesLine_out,
  input  logic              i01_spikesLine_valid,
  input  logic [LINE_W-1:0] i02_spikesLine_out,
  input  logic              i02_spikesLine_valid,
  output logic [LINE_W-1:0] o_q_line,
  output logic [LINE_W-1:0] o_k_line,
  output logic [LINE_W-1:0] o_v_line,
  output logic              o_qkv_valid,
  input  logic              i_qkv_ready,
  output logic              o_qkv_last,
  output logic [2:0]        o_overflow,
  output logic              o_frame_done
);
  localparam int CW = $clog2(LINES_PER_FRAME);
  localparam logic [CW-1:0] LAST_IDX = CW'(LINES_PER_FRAME - 1);
  logic [LINE_W-1:0] w_din  [3];
  logic [LINE_W-1:0] w_dout [3];
  logic [2:0] w_wr;
  logic [2:0] w_full;
  logic [2:0] w_empty;
  logic [2:0] w_drop;
  logic w_accept;
  logic w_pop;
  logic [CW-1:0] r_cnt;
  logic r_valid;
  logic r_last;
  logic r_done;
  logic [2:0] r_ovf;
  logic [LINE_W-1:0] r_q;
  logic [LINE_W-1:0] r_k;
  logic [LINE_W-1:0] r_v;
  assign w_din[OVF_Q] = i00_spikesLine_out;
  assign w_din[OVF_K] = i01_spikesLine_out;
  assign w_din[OVF_V] = i02_spikesLine_out;
  assign w_wr[OVF_Q]  = i00_spikesLine_valid;
  assign w_wr[OVF_K]  = i01_spikesLine_valid;
  assign w_wr[OVF_V]  = i02_spikesLine_valid;
  assign w_accept = r_valid && i_qkv_ready;
  assign w_pop    = !(|w_empty) && (!r_valid || w_accept);
  for (genvar g = 0; g < 3; g++) begin : g_fifo
    qkv_line_fifo #(.W(LINE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(s_clk), .rst(s_rst), .din(w_din[g]), .wr_en(w_wr[g]), .rd_en(w_pop),
      .dout(w_dout[g]), .full(w_full[g]), .empty(w_empty[g]), .drop(w_drop[g])
    );
    a_drop_only_when_full: assert property (@(posedge s_clk) disable iff (s_rst) w_drop[g] |-> w_full[g]);
  end
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= '0;
      r_q     <= '0;
      r_k     <= '0;
      r_v     <= '0;
    end else begin
      r_done <= w_accept && r_last;
      r_ovf  <= r_ovf | w_drop;
      if (w_pop) begin
        r_q     <= w_dout[OVF_Q];
        r_k     <= w_dout[OVF_K];
        r_v     <= w_dout[OVF_V];
        r_valid <= 1'b1;
        r_last  <= r_cnt == LAST_IDX;
        r_cnt   <= r_cnt == LAST_IDX ? '0 : r_cnt + CW'(1);
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end
  assign o_q_line     = r_q;
  assign o_k_line     = r_k;
  assign o_v_line     = r_v;
  assign o_qkv_valid  = r_valid;
  assign o_qkv_last   = r_last;
  assign o_overflow   = r_ovf;
  assign o_frame_done = r_done;
endmodule

// File: tb/tb_qkv_line_aligner.sv
// tb_qkv_line_aligner: table vectors, directed corner sequences and random traffic against a queue-based model
module tb_qkv_line_aligner;
  import qkv_line_aligner_pkg::*;
  logic s_clk = 1'b0;
  logic s_rst = 1'b1;
  logic [LINE_W-1:0] qd = '0, kd = '0, vd = '0;
  logic qv = 1'b0, kv = 1'b0, vv = 1'b0, rdy = 1'b0;
  logic [LINE_W-1:0] o_q_line, o_k_line, o_v_line;
  logic o_qkv_valid, o_qkv_last, o_frame_done;
  logic [2:0] o_overflow;
  int checks = 0;
  int failures = 0;
  logic [LINE_W-1:0] mq0[$], mq1[$], mq2[$];
  logic [LINE_W-1:0] m_q, m_k, m_v;
  logic m_valid, m_last, m_done;
  logic [2:0] m_ovf;
  int m_cnt;

  qkv_line_aligner dut (
    .s_clk(s_clk), .s_rst(s_rst),
    .i00_spikesLine_out(qd), .i00_spikesLine_valid(qv),
    .i01_spikesLine_out(kd), .i01_spikesLine_valid(kv),
    .i02_spikesLine_out(vd), .i02_spikesLine_valid(vv),
    .o_q_line(o_q_line), .o_k_line(o_k_line), .o_v_line(o_v_line),
    .o_qkv_valid(o_qkv_valid), .i_qkv_ready(rdy), .o_qkv_last(o_qkv_last),
    .o_overflow(o_overflow), .o_frame_done(o_frame_done)
  );

  always #5 s_clk = ~s_clk;

  function automatic logic [LINE_W-1:0] mk(input int d);
    logic [LINE_W-1:0] r;
    r = '0;
    r[31:0] = d;
    return r;
  endfunction

  function automatic logic [LINE_W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mq0.delete(); mq1.delete(); mq2.delete();
    m_q = '0; m_k = '0; m_v = '0;
    m_valid = 0; m_last = 0; m_done = 0; m_ovf = '0; m_cnt = 0;
  endtask

  // one clock: drive inputs, advance the model by the stream rules, then compare after the edge
  task automatic cyc(input logic a, input logic b, input logic c,
                     input logic [LINE_W-1:0] da, input logic [LINE_W-1:0] db,
                     input logic [LINE_W-1:0] dc, input logic r);
    logic acc, pop;
    qv = a; kv = b; vv = c; qd = da; kd = db; vd = dc; rdy = r;
    acc = m_valid && r;
    pop = mq0.size() > 0 && mq1.size() > 0 && mq2.size() > 0 && (!m_valid || acc);
    m_done = acc && m_last;
    if (pop) begin
      m_q = mq0.pop_front(); m_k = mq1.pop_front(); m_v = mq2.pop_front();
      m_valid = 1;
      m_last = m_cnt == LINES_PER_FRAME - 1;
      m_cnt = (m_cnt + 1) % LINES_PER_FRAME;
    end else if (acc) m_valid = 0;
    if (a) begin if (mq0.size() < FIFO_DEPTH) mq0.push_back(da); else m_ovf[OVF_Q] = 1; end
    if (b) begin if (mq1.size() < FIFO_DEPTH) mq1.push_back(db); else m_ovf[OVF_K] = 1; end
    if (c) begin if (mq2.size() < FIFO_DEPTH) mq2.push_back(dc); else m_ovf[OVF_V] = 1; end
    @(posedge s_clk);
    #1;
    chk("valid", o_qkv_valid, m_valid);
    chk("overflow", o_overflow, m_ovf);
    chk("frame_done", o_frame_done, m_done);
    if (m_valid) begin
      chk("q_line", o_q_line, m_q);
      chk("k_line", o_k_line, m_k);
      chk("v_line", o_v_line, m_v);
      chk("last", o_qkv_last, m_last);
    end
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, '0, '0, r);
  endtask

  // asserts reset between edges and checks outputs before any clock edge occurs
  task automatic do_reset();
    qv = 0; kv = 0; vv = 0; rdy = 0;
    #2 s_rst = 1'b1;
    #1;
    chk("rst_valid", o_qkv_valid, 0);
    chk("rst_last", o_qkv_last, 0);
    chk("rst_done", o_frame_done, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_q", o_q_line, 0);
    chk("rst_k", o_k_line, 0);
    chk("rst_v", o_v_line, 0);
    model_clear();
    @(posedge s_clk);
    #3 s_rst = 1'b0;
  endtask

  typedef struct {
    logic qv, kv, vv, rdy;
    logic e_valid;
    logic [2:0] e_ovf;
    int e_q, e_k;
  } vec_t;

  initial begin
    vec_t tbl[10];
    int nq, nk, nv, first, nlast, ndone, seen;
    model_clear();
    tbl[0] = '{0, 1, 0, 0, 0, 3'b000, 0, 0};
    tbl[1] = '{0, 1, 0, 0, 0, 3'b000, 0, 0};
    tbl[2] = '{0, 1, 0, 0, 0, 3'b000, 0, 0};
    tbl[3] = '{0, 1, 0, 0, 0, 3'b000, 0, 0};
    tbl[4] = '{0, 1, 0, 0, 0, 3'b010, 0, 0};
    tbl[5] = '{0, 1, 0, 0, 0, 3'b010, 0, 0};
    tbl[6] = '{1, 0, 1, 0, 0, 3'b010, 0, 0};
    tbl[7] = '{0, 0, 0, 0, 1, 3'b010, 0, 1000};
    tbl[8] = '{0, 0, 0, 0, 1, 3'b010, 0, 1000};
    tbl[9] = '{0, 0, 0, 1, 0, 3'b010, 0, 0};
    @(posedge s_clk);
    #1;
    do_reset();

    nq = 0; nk = 0; nv = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].qv, tbl[i].kv, tbl[i].vv, mk(nq), mk(1000 + nk), mk(2000 + nv), tbl[i].rdy);
      nq += int'(tbl[i].qv); nk += int'(tbl[i].kv); nv += int'(tbl[i].vv);
      chk("tbl_valid", o_qkv_valid, tbl[i].e_valid);
      chk("tbl_ovf", o_overflow, tbl[i].e_ovf);
      if (tbl[i].e_valid) begin
        chk("tbl_q", o_q_line, mk(tbl[i].e_q));
        chk("tbl_k", o_k_line, mk(tbl[i].e_k));
      end
    end
    idle(5, 1);
    chk("ovf_sticky", o_overflow, 3'b010);
    do_reset();

    nlast = 0; ndone = 0;
    for (int i = 0; i < 64; i++) begin
      cyc(1, 1, 1, mk(i), mk(1000 + i), mk(2000 + i), 1);
      if (o_qkv_valid && o_qkv_last) begin nlast++; chk("aligned_last_idx", o_q_line, mk(63)); end
      if (o_frame_done) ndone++;
    end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, '0, '0, '0, 1);
      if (o_qkv_valid && o_qkv_last) begin nlast++; chk("aligned_last_idx", o_q_line, mk(63)); end
      if (o_frame_done) ndone++;
    end
    chk("aligned_nlast", nlast, 1);
    chk("aligned_ndone", ndone, 1);
    chk("aligned_ovf", o_overflow, 0);
    do_reset();

    first = -1;
    for (int c = 0; c < 20; c++) begin
      cyc(c <= 3, c >= 5 && c <= 8, c >= 10 && c <= 13, mk(c), mk(1000 + c - 5), mk(2000 + c - 10), 1);
      if (o_qkv_valid && first < 0) begin first = c + 1; chk("skew_first_q", o_q_line, mk(0)); end
    end
    chk("skew_first_cycle", first, 12);
    chk("skew_ovf", o_overflow, 0);
    do_reset();

    for (int i = 0; i < 3; i++) cyc(1, 1, 1, mk(i), mk(1000 + i), mk(2000 + i), 0);
    for (int i = 3; i < 20; i++) begin
      cyc(0, 0, 0, '0, '0, '0, 0);
      chk("bp_hold_valid", o_qkv_valid, 1);
      chk("bp_hold_q", o_q_line, mk(0));
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, '0, '0, '0, 1);
      if (i < 2) chk("bp_consec_q", o_q_line, mk(i + 1));
    end
    chk("bp_drained", o_qkv_valid, 0);
    do_reset();

    for (int i = 0; i < 5; i++) cyc(1, 1, 1, mk(i), mk(1000 + i), mk(2000 + i), 0);
    cyc(1, 1, 1, mk(5), mk(1005), mk(2005), 1);
    chk("full_pp_ovf", o_overflow, 0);
    chk("full_pp_q", o_q_line, mk(1));
    idle(8, 1);
    chk("full_pp_ovf_end", o_overflow, 0);
    do_reset();

    for (int i = 0; i < 32; i++) cyc(1, 1, 1, mk(i), mk(1000 + i), mk(2000 + i), i < 30);
    do_reset();
    seen = 0; nlast = 0;
    for (int i = 0; i < 70; i++) begin
      cyc(i < 64, i < 64, i < 64, mk(500 + i), mk(1500 + i), mk(2500 + i), 1);
      if (o_qkv_valid) begin
        seen++;
        if (seen == 1) chk("rst_restart_first", o_q_line, mk(500));
        if (o_qkv_last) begin nlast++; chk("rst_last_at_64", seen, 64); end
      end
    end
    chk("rst_restart_nlast", nlast, 1);
    do_reset();

    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70,
          rnd(), rnd(), rnd(), $urandom_range(0, 99) < 60);
    idle(10, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
